// File: rtl/tnn_feature_loader.sv
// tnn_feature_loader: streams raw features in, quantizes each to 2 bits
// against per-feature thresholds, presents an 8-feature frame to a
// combinational TNN classifier and returns one registered class bit per frame.
module tnn_feature_loader #(
  parameter int unsigned FEAT_W = 8,
  parameter int unsigned N_FEAT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  input  logic              s_last,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr,
  input  logic [FEAT_W-1:0] cfg_data,
  output logic [1:0]        cls_a,
  output logic [1:0]        cls_b,
  output logic [1:0]        cls_c,
  output logic [1:0]        cls_d,
  output logic [1:0]        cls_e,
  output logic [1:0]        cls_f,
  output logic [1:0]        cls_g,
  output logic [1:0]        cls_h,
  input  logic              cls_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_class,
  output logic              m_err,
  output logic [7:0]        err_cnt
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned N_THR = N_FEAT * 3;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ADR_W = 5;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_EVAL,
    ST_OUT
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         cls_q [N_FEAT];
  logic [1:0]         cls_nx [N_FEAT];
  logic [FEAT_W-1:0]  thr_q [N_THR];
  logic               s_ready_q, s_ready_d;
  logic               m_valid_q, m_valid_d;
  logic               m_class_q, m_class_d;
  logic               m_err_q, m_err_d;
  logic               err_nx_q, err_nx_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [ADR_W-1:0]   thr_base;
  logic [1:0]         q_val;

  // Quantize the incoming beat against the thresholds of the current feature.
  always_comb begin
    thr_base = ADR_W'(idx_q) * ADR_W'(3);
    q_val    = 2'(s_data >= thr_q[thr_base])
             + 2'(s_data >= thr_q[thr_base + ADR_W'(1)])
             + 2'(s_data >= thr_q[thr_base + ADR_W'(2)]);
  end

  // Threshold table; writes land on the edge, so a same-cycle beat sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_THR; i++) begin
        thr_q[i] <= FEAT_W'(((i % 3) + 1) << (FEAT_W - 2));
      end
    end else if (cfg_we && (cfg_addr < ADR_W'(N_THR))) begin
      thr_q[cfg_addr] <= cfg_data;
    end
  end

  // Next-state and datapath for the collect / evaluate / output sequence.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cls_nx    = cls_q;
    m_valid_d = m_valid_q;
    m_class_d = m_class_q;
    m_err_d   = m_err_q;
    err_nx_d  = err_nx_q;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      ST_COLLECT: begin
        if (s_valid && s_ready_q) begin
          cls_nx[idx_q] = q_val;
          if (idx_q == IDX_W'(N_FEAT - 1)) begin
            state_d  = ST_EVAL;
            err_nx_d = !s_last;
          end else if (s_last) begin
            // Short frame: drop it, clear the classifier inputs, count it.
            idx_d = '0;
            for (int unsigned i = 0; i < N_FEAT; i++) begin
              cls_nx[i] = '0;
            end
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + CNT_W'(1);
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_EVAL: begin
        m_class_d = cls_out;
        m_err_d   = err_nx_q;
        m_valid_d = 1'b1;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          idx_d     = '0;
          state_d   = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase

    s_ready_d = (state_d == ST_COLLECT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_COLLECT;
      idx_q     <= '0;
      for (int unsigned i = 0; i < N_FEAT; i++) begin
        cls_q[i] <= '0;
      end
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      m_class_q <= 1'b0;
      m_err_q   <= 1'b0;
      err_nx_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cls_q     <= cls_nx;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_class_q <= m_class_d;
      m_err_q   <= m_err_d;
      err_nx_q  <= err_nx_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_class = m_class_q;
  assign m_err   = m_err_q;
  assign err_cnt = err_cnt_q;
  assign cls_a   = cls_q[0];
  assign cls_b   = cls_q[1];
  assign cls_c   = cls_q[2];
  assign cls_d   = cls_q[3];
  assign cls_e   = cls_q[4];
  assign cls_f   = cls_q[5];
  assign cls_g   = cls_q[6];
  assign cls_h   = cls_q[7];

endmodule

// File: doc/tnn_feature_loader.md
# tnn_feature_loader

Sequential front end for the 2-bit-input combinational TNN classifiers (eight 2-bit feature inputs, one 1-bit class output). The block accepts raw feature samples over a valid/ready stream and quantizes each to 2 bits against programmable per-feature thresholds. It assembles an 8-feature frame, drives the classifier inputs, samples the class bit, and returns one result per frame over an output valid/ready handshake.

## Interface
- FEAT_W, 8: raw feature width in bits (>= 2).
- N_FEAT, 8: features per frame; fixed at 8 to match the classifier port count.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  raw feature beat valid.
- s_ready  out  1  loader can accept a beat.
- s_data  in  FEAT_W  raw feature value, unsigned.
- s_last  in  1  marks the final feature of a frame.
- cfg_we  in  1  threshold write strobe.
- cfg_addr  in  5  threshold index = feature*3 + k, with k in 0..2.
- cfg_data  in  FEAT_W  threshold value, unsigned.
- cls_a … cls_h  out  2 each  quantized features 0..7 to the classifier (input_a..input_h).
- cls_out  in  1  classifier result (cgp_out[0]).
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_class  out  1  registered class bit.
- m_err  out  1  frame had 8 beats but the 8th lacked s_last.
- err_cnt  out  8  dropped-frame counter; saturates at 255.

## Operation
- **Quantization.** q = (x >= T0) + (x >= T1) + (x >= T2), using unsigned compares and that feature's thresholds. The range is 0..3 for any threshold order.
- **Threshold reset values.** Tk = (k+1) << (FEAT_W-2). With FEAT_W=8 these are 0x40, 0x80, 0xC0.
- **Threshold writes.** cfg writes are accepted in any state. Addresses 24..31 are ignored. A write applies to beats accepted from the next cycle onward. If a beat and a write to that beat's threshold fall in the same cycle, the beat uses the old value.
- **State COLLECT.**
  - s_ready=1, with feature index idx counting 0..7.
  - On s_valid&s_ready, q is registered into cls_[idx] and idx increments.
  - If s_last is set and idx<7: the frame is dropped, err_cnt increments (saturating), idx returns to 0, cls_* are cleared to 0, and there is no result.
  - If idx==7: go to EVAL, and m_err_next = !s_last.
- **State EVAL.** One cycle, s_ready=0, cls_* stable. At the end of the cycle: m_class <= cls_out, m_err <= m_err_next, m_valid <= 1. Then go to OUT.
- **State OUT.** s_ready=0, and m_valid/m_class/m_err are held stable until m_ready. On m_valid&m_ready: m_valid <= 0, idx <= 0, and the state goes to COLLECT. cls_* keep their last values until overwritten.
- **Frame spacing.** There is no overlap between frames. s_ready stays 0 from the cycle after the 8th beat until the cycle after the result handshake.
- **Reset values (any time, including mid-frame).** State COLLECT, idx=0, s_ready=1 after release, cls_*=0, m_valid=0, m_class=0, m_err=0, err_cnt=0, thresholds at their reset values. A partial frame is lost without counting as an error.

## Timing
- 8th beat accepted at edge N: EVAL occupies cycle N..N+1, and m_valid is high after edge N+1. Latency is 1 cycle after the last beat.
- cls_out must settle within one clock period of cls_* changing. The classifier path is single-cycle combinational.
- Back-to-back frames with m_ready tied high: a 10-cycle period (8 COLLECT + EVAL + OUT).
- m_valid never drops without m_ready. m_class/m_err do not change while m_valid=1.
- err_cnt updates on the edge that accepts the early s_last beat.

## Test plan
- **Reset thresholds, FEAT_W=8.** Beats 0x00,0x3F,0x40,0x7F,0x80,0xBF,0xC0,0xFF (last on 8th) → cls_a..h = 0,0,1,1,2,2,3,3; m_valid exactly 1 cycle after the 8th beat; m_class = cls_out as driven by a stub; m_err=0.
- **Backpressure.** Hold m_ready=0 for 5 cycles → m_valid and m_class stable, s_ready=0 throughout. Raise m_ready → s_ready=1 the next cycle.
- **Config.** Write feature 2 thresholds to 0x10, 0x20, 0x30 (addr 6,7,8). A frame with feature 2 = 0x25 → cls_c=2. A write to addr 30 → no threshold change.
- **Early s_last on 3rd beat.** err_cnt 0→1, no m_valid, the next 8 beats form a valid frame. Repeating 300 dropped frames → err_cnt=255.
- **8th beat without s_last.** Result issued with m_err=1. The next beat is feature 0 of a new frame.
- **rst_n asserted asynchronously after 5 beats.** All outputs return to reset values immediately. After release, a full 8-beat frame produces one result with m_err=0.
